// File: rtl/ser2para_rx.sv
// ser2para_rx: receiver for the 4-wire display serial bundle {SEGCLK,SEGCLR,SEGDT,SEGEN}.
// Rebuilds the WIDTH-bit word. Define CHANGE_FILTER_EN to strobe only words that differ from the current one.
module ser2para_rx #(
  parameter int WIDTH       = 24,
  parameter int SYNC_STAGES = 2,   // at least 2
  parameter int TIMEOUT     = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       sin,
  output logic [WIDTH-1:0] num,
  output logic             valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LP_CNT_LAST = CW'(WIDTH - 1);
  localparam logic [TW-1:0] LP_TMO_LAST = TW'(TIMEOUT - 1);
  localparam int B_CLK = 3;
  localparam int B_CLR = 2;
  localparam int B_DT  = 1;
  localparam int B_EN  = 0;
  // SEGCLR idles high, so its chain resets to 1 and no clear is seen right after reset.
  localparam logic [3:0] LP_SYNC_RST = 4'b0100;

  typedef enum logic {S_IDLE, S_RECV} state_t;

  logic [SYNC_STAGES-1:0][3:0] r_sync;
  logic                        r_clk_d;
  state_t                      r_state;
  logic [CW-1:0]               r_cnt;
  logic [WIDTH-2:0]            r_shift;
  logic [TW-1:0]               r_tmo;
  logic [WIDTH-1:0]            r_num;
  logic                        r_valid;
  logic                        r_err;

  logic [3:0]       w_sync;
  logic             w_rise;
  logic             w_accept;
  logic             w_clear;
  logic [WIDTH-1:0] w_word;
  logic             w_publish;
  state_t           w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-2:0] w_shift_nxt;
  logic [TW-1:0]    w_tmo_nxt;
  logic [WIDTH-1:0] w_num_nxt;
  logic             w_valid_nxt;
  logic             w_err_nxt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync  <= {SYNC_STAGES{LP_SYNC_RST}};
      r_clk_d <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], sin};
      r_clk_d <= r_sync[SYNC_STAGES-1][B_CLK];
    end
  end

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_rise   = w_sync[B_CLK] & ~r_clk_d;
  assign w_clear  = ~w_sync[B_CLR];
  assign w_accept = w_rise & w_sync[B_EN] & w_sync[B_CLR];
  assign w_word   = {r_shift, w_sync[B_DT]};

`ifdef CHANGE_FILTER_EN
  logic r_have;
  logic w_have_nxt;

  // The first word after reset always publishes, even when it equals the reset value.
  assign w_publish = ~r_have | (w_word != r_num);

  always_ff @(posedge clk) begin
    if (!rst_n) r_have <= 1'b0;
    else        r_have <= w_have_nxt;
  end

  always_comb begin
    w_have_nxt = r_have;
    if (w_valid_nxt) w_have_nxt = 1'b1;
  end
`else
  assign w_publish = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_tmo   <= '0;
      r_num   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_tmo   <= w_tmo_nxt;
      r_num   <= w_num_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_tmo_nxt   = r_tmo;
    w_num_nxt   = r_num;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;

    if (w_clear) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_shift_nxt = '0;
      w_tmo_nxt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_state_nxt = S_RECV;
            w_cnt_nxt   = CW'(1);
            w_shift_nxt = w_word[WIDTH-2:0];
            w_tmo_nxt   = '0;
          end
        end
        S_RECV: begin
          if (w_accept) begin
            w_tmo_nxt = '0;
            if (r_cnt == LP_CNT_LAST) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
              w_shift_nxt = '0;
              if (w_publish) begin
                w_num_nxt   = w_word;
                w_valid_nxt = 1'b1;
              end
            end else begin
              w_cnt_nxt   = r_cnt + CW'(1);
              w_shift_nxt = w_word[WIDTH-2:0];
            end
          end else if (r_tmo == LP_TMO_LAST) begin
            // Sender went silent mid-frame: drop the partial word, keep num.
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_shift_nxt = '0;
            w_tmo_nxt   = '0;
            w_err_nxt   = 1'b1;
          end else begin
            w_tmo_nxt = r_tmo + TW'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign num       = r_num;
  assign valid     = r_valid;
  assign frame_err = r_err;
  assign busy      = (r_state == S_RECV);

endmodule

// File: doc/ser2para_rx.md
Name: ser2para_rx

Overview:
- Receive-side counterpart of the 24-bit display serializer.
- Accepts the 4-wire serial bundle {SEGCLK,SEGCLR,SEGDT,SEGEN} and reconstructs the 24-bit parallel word.
- Presents the word with a one-cycle valid strobe.
- Used in loopback verification and on a second board fed by the scoreboard link; runs on its own system clock, asynchronous to the sender.

Parameters:
- WIDTH, 24: data bits per frame.
- SYNC_STAGES, 2: synchronizer flops on each serial input, minimum 2.
- TIMEOUT, 64: clk cycles with no SEGCLK edge before a partial frame is discarded.

Ports:
- clk  input  1  system clock; frequency at least 4x the sender clock.
- rst_n  input  1  synchronous active-low reset.
- sin  input  4  serial bundle {SEGCLK,SEGCLR,SEGDT,SEGEN}, bit 3 = SEGCLK; asynchronous to clk.
- num  output  WIDTH  last complete received word.
- valid  output  1  one-cycle strobe: num updated this cycle.
- frame_err  output  1  one-cycle strobe: partial frame aborted by timeout.
- busy  output  1  high while a frame is partially received.

Behaviour:
- Reset (rst_n low at posedge clk):
  - num=0, valid=0, frame_err=0, busy=0.
  - Bit counter=0, shift register=0, timeout counter=0.
  - All synchronizer flops=0, except the SEGCLR chain, which resets to 1.
- Synchronization and edge detection:
  - Each sin bit passes through SYNC_STAGES flops; all four chains have equal length.
  - One extra flop on synced SEGCLK gives edge detection: rise = synced_clk & ~synced_clk_d.
- Sampling:
  - On rise with synced SEGEN=1 and synced SEGCLR=1, shift synced SEGDT into the LSB.
  - Data is MSB first: first sampled bit becomes num[WIDTH-1].
  - Rises with SEGEN=0 are ignored entirely; the timeout counter is not cleared.
- States:
  - IDLE: bit counter 0, busy=0.
    - Accepted rise: store bit, counter=1, go RECV.
  - RECV: busy=1.
    - Each accepted rise increments the counter and clears the timeout counter.
    - On the rise that makes counter=WIDTH, num is loaded next cycle with the full word, valid=1 for exactly that cycle, then return to IDLE.
    - Otherwise the timeout counter increments each cycle. When it reaches TIMEOUT-1: frame_err=1 for one cycle, shift register discarded, num unchanged, return to IDLE.
- SEGCLR:
  - Synced SEGCLR=0 in any state forces IDLE with counter and shift register cleared.
  - No frame_err, num unchanged.
  - Overrides a coincident rise.
- Simultaneous events: a rise arriving in the cycle the timeout expires is sampled; the timeout is cancelled.
- Latency: valid asserts SYNC_STAGES+2 clk cycles after the final SEGCLK rising edge at the pins, ±1 cycle for synchronizer phase.
- Idle line: after the final bit the sender leaves SEGCLK low and SEGDT=1. No edge occurs, so nothing is sampled.
- Back-to-back frames: a new first bit may arrive the cycle after valid; it is accepted.
- Reset mid-frame discards the partial frame with no strobes.
- Widths: bit counter is clog2(WIDTH+1) bits; timeout counter is clog2(TIMEOUT) bits and saturates.

Optional Feature:
- CHANGE_FILTER_EN
- Defined:
  - A completed frame updates num and strobes valid only if the word differs from the current num.
  - Identical repeats complete silently, return to IDLE, and leave busy behaviour unchanged.
  - The first frame after reset always strobes, even if it equals 0.
- Undefined: every completed frame strobes valid.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with random sin -> num=0, valid=0, frame_err=0, busy=0 after release.
- Single frame: sender serializes 24'hA5C3F0 at clk/4 -> exactly one valid pulse with num=24'hA5C3F0; busy high from first rise until the valid cycle.
- Back-to-back: frames 24'h000001 then 24'hFFFFFE with no gap -> two valid pulses, num values in order, no frame_err.
- Timeout: send 10 bits then stop -> frame_err pulse TIMEOUT cycles after the last rise; num unchanged; a following full frame 24'h123456 is received correctly.
- Gating:
  - Pulse SEGCLR=0 mid-frame -> return to IDLE, no strobes; the subsequent frame is received correctly.
  - Toggle SEGCLK with SEGEN=0 -> no bits counted.
- CHANGE_FILTER_EN: send 24'h0000FF three times -> one valid pulse when defined, three when undefined.
